cpu_run_monitor: RTL
====================

Name: cpu_run_monitor

Overview:
- Parametrised run controller and commit monitor for the single-cycle RV32I core.
- Gates the core via a start/done handshake, counts cycles, retired instructions, register-file writes and data-memory writes, and folds committed register writes into a rolling signature.
- Detects program end by ECALL or PC self-loop, and bounds every run with a cycle-limit timeout.
- Replaces fixed-delay run windows in benches; also usable as an on-chip run/debug block.

Parameters:
XLEN, 32, datapath width of pc, rf_wdata, dm_addr, dm_wdata and signature
CNT_W, 32, width of all counters
MAX_CYCLES, 1000, run-cycle limit before timeout; must be >= 2
HALT_REPEAT, 2, consecutive committed cycles with unchanged pc that signal a halt; must be >= 1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset; rst=0 resets all state immediately
start  input  1  run request; sampled in IDLE, DONE or TIMEOUT
core_en  output  1  core clock-enable / commit-enable
pc  input  XLEN  pc of the instruction committing this cycle
instr  input  32  instruction committing this cycle
instr_valid  input  1  a commit occurs this cycle; ignored unless core_en=1
rf_we  input  1  register-file write strobe
rf_waddr  input  5  register-file write address
rf_wdata  input  XLEN  register-file write data
dm_we  input  1  data-memory write strobe
dm_addr  input  XLEN  data-memory address
dm_wdata  input  XLEN  data-memory write data
busy  output  1  high in RUN
done  output  1  high in DONE
timeout  output  1  high in TIMEOUT
cycle_cnt  output  CNT_W  cycles spent in RUN
instret  output  CNT_W  retired instructions
rf_wr_cnt  output  CNT_W  register writes with rf_waddr != 0
dm_wr_cnt  output  CNT_W  data-memory writes
signature  output  XLEN  rolling write signature

Behaviour:
- Reset (rst=0): state=IDLE; core_en, busy, done, timeout = 0; all counters, signature and the pc-repeat counter = 0.
- States: IDLE, RUN, DONE, TIMEOUT. All outputs are registered or decoded directly from state; no combinational path from inputs to outputs.
- IDLE/DONE/TIMEOUT with start=1: next state is RUN; counters, signature and repeat counter clear on that edge. Otherwise counters hold their values.
- RUN:
  - core_en=1.
  - cycle_cnt increments every cycle.
  - When instr_valid=1:
    - instret increments.
    - If rf_we=1 and rf_waddr!=0: rf_wr_cnt increments and signature <= rotl1(signature) ^ rf_wdata ^ zero-extended rf_waddr.
    - If dm_we=1: dm_wr_cnt increments.
  - Strobes with instr_valid=0 are ignored.
- Halt detection, evaluated on committed cycles only:
  - instr == 32'h00000073 (ECALL) -> DONE on the next edge.
  - pc equal to the previously committed pc increments the repeat counter; any other pc resets it to 0. The repeat counter reaching HALT_REPEAT -> DONE.
  - The halting instruction itself is counted in instret.
- Timeout: cycle_cnt == MAX_CYCLES-1 in RUN -> TIMEOUT. If halt and timeout occur in the same cycle, DONE wins.
- In DONE/TIMEOUT: core_en=0, and the matching flag stays high until the next start or reset.
- Counters saturate at all-ones; they never wrap.
- start=1 while in RUN is ignored.
- Reset asserted mid-run aborts immediately to IDLE with everything cleared; core_en falls asynchronously.

Optional Feature:
- Macro: MON_DM_SIG_EN.
- Defined: each committed dm_we also applies signature <= rotl1(signature) ^ dm_wdata ^ dm_addr. If an rf write and a dm write occur in the same cycle, the rf fold is applied first and the dm fold is applied to that result.
- Undefined: data-memory writes do not affect signature; dm_wr_cnt still counts.

Test Plan:
- Reset then start pulse; commit 5 ALU instructions writing x1..x5 with data 10..50, then ECALL -> done=1; instret=6; rf_wr_cnt=5; core_en=0 one cycle after the ECALL commit.
- Commit with rf_we=1, rf_waddr=0, rf_wdata=32'hFFFF_FFFF -> rf_wr_cnt unchanged; signature unchanged.
- pc sequence 0,4,8,8,8 with HALT_REPEAT=2 -> done=1 after the second repeat of pc=8; instret=5.
- MAX_CYCLES=20 with pc always advancing -> timeout=1; cycle_cnt=19; done=0.
- One sw of 42 to address 0, then ECALL -> dm_wr_cnt=1. With MON_DM_SIG_EN, signature = rotl1(0) ^ 42 ^ 0 = 42. Without it, signature = 0.
- rst driven to 0 mid-run at cycle 7 -> busy=0, core_en=0 and cycle_cnt=0 immediately, without waiting for a clock edge; a new start then runs normally.

Source files
------------

// File: rtl/cpu_run_monitor_if.sv
// Run-control and commit-trace bundle between an RV32I core/bench and cpu_run_monitor.
// The master drives start and the commit trace; the slave (monitor) returns status and counters.
interface cpu_run_monitor_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) ();
  logic             start;
  logic             core_en;
  logic [XLEN-1:0]  pc;
  logic [31:0]      instr;
  logic             instr_valid;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             dm_we;
  logic [XLEN-1:0]  dm_addr;
  logic [XLEN-1:0]  dm_wdata;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret;
  logic [CNT_W-1:0] rf_wr_cnt;
  logic [CNT_W-1:0] dm_wr_cnt;
  logic [XLEN-1:0]  signature;

  modport master (
    output start, pc, instr, instr_valid, rf_we, rf_waddr, rf_wdata,
           dm_we, dm_addr, dm_wdata,
    input  core_en, busy, done, timeout, cycle_cnt, instret, rf_wr_cnt,
           dm_wr_cnt, signature
  );

  modport slave (
    input  start, pc, instr, instr_valid, rf_we, rf_waddr, rf_wdata,
           dm_we, dm_addr, dm_wdata,
    output core_en, busy, done, timeout, cycle_cnt, instret, rf_wr_cnt,
           dm_wr_cnt, signature
  );
endinterface

// File: rtl/cpu_run_monitor.sv
// Run controller + commit monitor: start/done gating, saturating counters, write signature, halt/timeout.
// All outputs registered or state-decoded (one-edge latency); MON_DM_SIG_EN also folds dm writes into the signature.
module cpu_run_monitor #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 1000,
  parameter int HALT_REPEAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  cpu_run_monitor_if.slave mon
);

  localparam int               REP_W     = $clog2(HALT_REPEAT + 1);
  localparam logic [REP_W-1:0] REP_TGT   = REP_W'(HALT_REPEAT);
  localparam logic [CNT_W-1:0] CYC_LIMIT = CNT_W'(MAX_CYCLES - 1);
  localparam logic [31:0]      ECALL     = 32'h0000_0073;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TIMEOUT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [CNT_W-1:0] rf_wr_cnt_q, rf_wr_cnt_d;
  logic [CNT_W-1:0] dm_wr_cnt_q, dm_wr_cnt_d;
  logic [XLEN-1:0]  sig_q, sig_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [XLEN-1:0]  prev_pc_q, prev_pc_d;
  logic             prev_vld_q, prev_vld_d;

  logic [XLEN-1:0]  sig_tmp;
  logic             halt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [XLEN-1:0] rotl1(input logic [XLEN-1:0] v);
    return {v[XLEN-2:0], v[XLEN-1]};
  endfunction

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    instret_d   = instret_q;
    rf_wr_cnt_d = rf_wr_cnt_q;
    dm_wr_cnt_d = dm_wr_cnt_q;
    sig_d       = sig_q;
    rep_d       = rep_q;
    prev_pc_d   = prev_pc_q;
    prev_vld_d  = prev_vld_q;
    sig_tmp     = sig_q;
    halt        = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (mon.start) begin
          state_d     = S_RUN;
          cycle_cnt_d = '0;
          instret_d   = '0;
          rf_wr_cnt_d = '0;
          dm_wr_cnt_d = '0;
          sig_d       = '0;
          rep_d       = '0;
          prev_pc_d   = '0;
          prev_vld_d  = 1'b0;
        end
      end
      S_RUN: begin
        cycle_cnt_d = sat_inc(cycle_cnt_q);
        if (mon.instr_valid) begin
          instret_d = sat_inc(instret_q);
          if (mon.rf_we && (mon.rf_waddr != 5'd0)) begin
            rf_wr_cnt_d = sat_inc(rf_wr_cnt_q);
            sig_tmp     = rotl1(sig_tmp) ^ mon.rf_wdata ^ XLEN'(mon.rf_waddr);
          end
          if (mon.dm_we) begin
            dm_wr_cnt_d = sat_inc(dm_wr_cnt_q);
`ifdef MON_DM_SIG_EN
            sig_tmp     = rotl1(sig_tmp) ^ mon.dm_wdata ^ mon.dm_addr;
`endif
          end
          sig_d = sig_tmp;
          // The first commit of a run has no predecessor, so it can never count as a repeat.
          if (prev_vld_q && (mon.pc == prev_pc_q)) rep_d = rep_q + REP_W'(1);
          else                                     rep_d = '0;
          prev_pc_d  = mon.pc;
          prev_vld_d = 1'b1;
          halt       = (mon.instr == ECALL) || (rep_d == REP_TGT);
        end
        // Timeout fires on the edge that brings cycle_cnt to MAX_CYCLES-1; a halt on that edge wins.
        if (halt)                            state_d = S_DONE;
        else if (cycle_cnt_d == CYC_LIMIT)   state_d = S_TIMEOUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cycle_cnt_q <= '0;
      instret_q   <= '0;
      rf_wr_cnt_q <= '0;
      dm_wr_cnt_q <= '0;
      sig_q       <= '0;
      rep_q       <= '0;
      prev_pc_q   <= '0;
      prev_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      instret_q   <= instret_d;
      rf_wr_cnt_q <= rf_wr_cnt_d;
      dm_wr_cnt_q <= dm_wr_cnt_d;
      sig_q       <= sig_d;
      rep_q       <= rep_d;
      prev_pc_q   <= prev_pc_d;
      prev_vld_q  <= prev_vld_d;
    end
  end

  assign mon.core_en   = (state_q == S_RUN);
  assign mon.busy      = (state_q == S_RUN);
  assign mon.done      = (state_q == S_DONE);
  assign mon.timeout   = (state_q == S_TIMEOUT);
  assign mon.cycle_cnt = cycle_cnt_q;
  assign mon.instret   = instret_q;
  assign mon.rf_wr_cnt = rf_wr_cnt_q;
  assign mon.dm_wr_cnt = dm_wr_cnt_q;
  assign mon.signature = sig_q;

endmodule
